// File: rtl/entrada_numerica_teclado.sv
// Keypad entry accumulator: digits build a right-aligned BCD buffer,
// A commits, B deletes the last digit, C clears; D/E/F are ignored.
// Ports: clk, rst (async, active-high), tecla_value/tecla_valid in;
//   digitos, num_digitos, numero, numero_valid, erro out (all registered).
// Optional: define ENTRADA_TIMEOUT_EN to auto-clear an idle buffer
//   after TIMEOUT_CICLOS cycles (pulses erro).
module entrada_numerica_teclado #(
  parameter int N_DIGITOS      = 4,
  parameter int TIMEOUT_CICLOS = 50_000_000
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [3:0]                         tecla_value,
  input  logic                               tecla_valid,
  output logic [4*N_DIGITOS-1:0]             digitos,
  output logic [$clog2(N_DIGITOS+1)-1:0]     num_digitos,
  output logic [4*N_DIGITOS-1:0]             numero,
  output logic                               numero_valid,
  output logic                               erro
);

  localparam int DW = 4 * N_DIGITOS;
  localparam int NW = $clog2(N_DIGITOS + 1);

  typedef enum logic [1:0] {
    ESPERA,
    CAPTURA,
    SOLTA
  } estado_t;

  estado_t       estado, estado_n;
  logic [3:0]    tecla_reg, tecla_n;
  logic [DW-1:0] dig_n, num_conv, numero_n;
  logic [NW-1:0] cnt_dig_n;
  logic          nv_n, erro_n;

`ifdef ENTRADA_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CICLOS + 1);
  logic [CW-1:0] tempo, tempo_n;
`endif

  // Committed value: blank nibbles read as zero.
  always_comb begin
    num_conv = digitos;
    for (int i = 0; i < N_DIGITOS; i++) begin
      if (digitos[4*i +: 4] == 4'hF) num_conv[4*i +: 4] = 4'h0;
    end
  end

  always_comb begin
    estado_n  = estado;
    tecla_n   = tecla_reg;
    dig_n     = digitos;
    cnt_dig_n = num_digitos;
    numero_n  = numero;
    nv_n      = 1'b0;
    erro_n    = 1'b0;
`ifdef ENTRADA_TIMEOUT_EN
    tempo_n   = tempo;
`endif
    unique case (estado)
      ESPERA: begin
`ifdef ENTRADA_TIMEOUT_EN
        if (num_digitos != '0) begin
          if (tempo == CW'(TIMEOUT_CICLOS - 1)) begin
            dig_n     = '1;
            cnt_dig_n = '0;
            tempo_n   = '0;
            erro_n    = 1'b1;
          end else begin
            tempo_n = tempo + CW'(1);
          end
        end
`endif
        if (tecla_valid) begin
          tecla_n  = tecla_value;
          estado_n = CAPTURA;
        end
      end
      CAPTURA: begin
        estado_n = SOLTA;
        unique case (1'b1)
          (tecla_reg <= 4'd9): begin
            if (num_digitos == NW'(N_DIGITOS)) begin
              erro_n = 1'b1;
            end else begin
              dig_n     = (digitos << 4) | DW'(tecla_reg);
              cnt_dig_n = num_digitos + NW'(1);
            end
          end
          (tecla_reg == 4'hA): begin
            if (num_digitos == '0) begin
              erro_n = 1'b1;
            end else begin
              numero_n  = num_conv;
              nv_n      = 1'b1;
              dig_n     = '1;
              cnt_dig_n = '0;
            end
          end
          (tecla_reg == 4'hB): begin
            if (num_digitos != '0) begin
              // Refill the vacated MSB nibble with blank.
              dig_n     = (digitos >> 4) | (DW'(4'hF) << (DW - 4));
              cnt_dig_n = num_digitos - NW'(1);
            end
          end
          (tecla_reg == 4'hC): begin
            dig_n     = '1;
            cnt_dig_n = '0;
          end
          default: ;
        endcase
      end
      SOLTA: begin
        if (!tecla_valid) estado_n = ESPERA;
      end
      default: estado_n = ESPERA;
    endcase
`ifdef ENTRADA_TIMEOUT_EN
    if (estado_n == CAPTURA) tempo_n = '0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado       <= ESPERA;
      tecla_reg    <= '0;
      digitos      <= '1;
      num_digitos  <= '0;
      numero       <= '0;
      numero_valid <= 1'b0;
      erro         <= 1'b0;
`ifdef ENTRADA_TIMEOUT_EN
      tempo        <= '0;
`endif
    end else begin
      estado       <= estado_n;
      tecla_reg    <= tecla_n;
      digitos      <= dig_n;
      num_digitos  <= cnt_dig_n;
      numero       <= numero_n;
      numero_valid <= nv_n;
      erro         <= erro_n;
`ifdef ENTRADA_TIMEOUT_EN
      tempo        <= tempo_n;
`endif
    end
  end

endmodule

// File: tb/tb_entrada_numerica_teclado.sv
// Bench for entrada_numerica_teclado (N_DIGITOS=4): keystroke table
// with a scoreboard queue, plus reset-mid-hold and idle sequences.
module tb_entrada_numerica_teclado;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  tecla_value = '0;
  logic        tecla_valid = 1'b0;
  logic [15:0] digitos;
  logic [2:0]  num_digitos;
  logic [15:0] numero;
  logic        numero_valid;
  logic        erro;

  int checks = 0;
  int errors = 0;
  int nv_cnt = 0;
  int er_cnt = 0;

  typedef struct {
    logic [3:0]  key;
    int          hold;
    logic [15:0] dig;
    logic [2:0]  num;
    logic [15:0] numero;
    int          nv;
    int          er;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[18];

  entrada_numerica_teclado #(
    .N_DIGITOS(4),
    .TIMEOUT_CICLOS(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tecla_value(tecla_value),
    .tecla_valid(tecla_valid),
    .digitos(digitos),
    .num_digitos(num_digitos),
    .numero(numero),
    .numero_valid(numero_valid),
    .erro(erro)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (numero_valid) nv_cnt++;
    if (erro) er_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_dig"}, 32'(digitos), 32'h0000FFFF);
    chk({tag, "_num"}, 32'(num_digitos), 32'd0);
    chk({tag, "_numero"}, 32'(numero), 32'd0);
    chk({tag, "_nv"}, 32'(numero_valid), 32'd0);
    chk({tag, "_erro"}, 32'(erro), 32'd0);
  endtask

  // Called #1 after a posedge with the DUT idle in ESPERA.
  task automatic press(input vec_t v);
    int   nv0, er0;
    vec_t e;
    nv0 = nv_cnt;
    er0 = er_cnt;
    tecla_value = v.key;
    tecla_valid = 1'b1;
    sb.push_back(v);
    for (int i = 0; i < v.hold; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) begin
        e = sb.pop_front();
        chk($sformatf("k%h_dig", e.key), 32'(digitos), 32'(e.dig));
        chk($sformatf("k%h_num", e.key), 32'(num_digitos), 32'(e.num));
        chk($sformatf("k%h_numero", e.key), 32'(numero),
            32'(e.numero));
      end
    end
    tecla_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk($sformatf("k%h_nv_pulses", v.key), 32'(nv_cnt - nv0), 32'(v.nv));
    chk($sformatf("k%h_er_pulses", v.key), 32'(er_cnt - er0), 32'(v.er));
  endtask

  initial begin
    vec_t v;
    int   er0;

    tbl = '{
      '{4'h1, 5, 16'hFFF1, 3'd1, 16'h0000, 0, 0},
      '{4'h2, 5, 16'hFF12, 3'd2, 16'h0000, 0, 0},
      '{4'h3, 5, 16'hF123, 3'd3, 16'h0000, 0, 0},
      '{4'h4, 3, 16'h1234, 3'd4, 16'h0000, 0, 0},
      '{4'h5, 3, 16'h1234, 3'd4, 16'h0000, 0, 1},
      '{4'hC, 2, 16'hFFFF, 3'd0, 16'h0000, 0, 0},
      '{4'h9, 2, 16'hFFF9, 3'd1, 16'h0000, 0, 0},
      '{4'h8, 4, 16'hFF98, 3'd2, 16'h0000, 0, 0},
      '{4'hB, 2, 16'hFFF9, 3'd1, 16'h0000, 0, 0},
      '{4'h7, 2, 16'hFF97, 3'd2, 16'h0000, 0, 0},
      '{4'hA, 3, 16'hFFFF, 3'd0, 16'h0097, 1, 0},
      '{4'hA, 2, 16'hFFFF, 3'd0, 16'h0097, 0, 1},
      '{4'hC, 2, 16'hFFFF, 3'd0, 16'h0097, 0, 0},
      '{4'hD, 2, 16'hFFFF, 3'd0, 16'h0097, 0, 0},
      '{4'hB, 2, 16'hFFFF, 3'd0, 16'h0097, 0, 0},
      '{4'hE, 2, 16'hFFFF, 3'd0, 16'h0097, 0, 0},
      '{4'h0, 2, 16'hFFF0, 3'd1, 16'h0097, 0, 0},
      '{4'hA, 2, 16'hFFFF, 3'd0, 16'h0000, 1, 0}
    };

    #12;
    chk_reset("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 18; i++) press(tbl[i]);

    // Long hold: a single action only.
    v = '{4'h5, 200, 16'hFFF5, 3'd1, 16'h0000, 0, 0};
    press(v);

    // Reset asserted mid-hold, released with the key still down.
    tecla_value = 4'h6;
    tecla_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("hold6_dig", 32'(digitos), 32'h0000FF56);
    #2;
    rst = 1'b1;
    #1;
    chk_reset("async_rst");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("post_rst_dig", 32'(digitos), 32'h0000FFF6);
    chk("post_rst_num", 32'(num_digitos), 32'd1);
    tecla_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;

    v = '{4'hC, 2, 16'hFFFF, 3'd0, 16'h0000, 0, 0};
    press(v);
    v = '{4'h3, 2, 16'hFFF3, 3'd1, 16'h0000, 0, 0};
    press(v);
    er0 = er_cnt;
`ifdef ENTRADA_TIMEOUT_EN
    // ESPERA was entered two edges before press returned.
    repeat (18) @(posedge clk);
    #1;
    chk("to_before_dig", 32'(digitos), 32'h0000FFF3);
    @(posedge clk);
    #1;
    chk("to_dig", 32'(digitos), 32'h0000FFFF);
    chk("to_num", 32'(num_digitos), 32'd0);
    chk("to_erro", 32'(erro), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("to_er_pulses", 32'(er_cnt - er0), 32'd1);
`else
    repeat (1000) @(posedge clk);
    #1;
    chk("idle_dig", 32'(digitos), 32'h0000FFF3);
    chk("idle_num", 32'(num_digitos), 32'd1);
    chk("idle_er_pulses", 32'(er_cnt - er0), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
